// File: rtl/guess_solver_if.sv
// guess_solver_if: start/abort/feedback handshake and guess/status outputs of the guess solver.
interface guess_solver_if;
    logic       start;
    logic       abort;
    logic [5:0] feedback;
    logic       fb_valid;
    logic [5:0] guess;
    logic       guess_strobe;
    logic       busy;
    logic       solved;
    logic       fail;
    logic [2:0] attempts;
    logic [7:0] wins;
    modport master (
        output start, abort, feedback, fb_valid,
        input  guess, guess_strobe, busy, solved, fail, attempts, wins
    );
    modport slave (
        input  start, abort, feedback, fb_valid,
        output guess, guess_strobe, busy, solved, fail, attempts, wins
    );
endinterface

// File: rtl/guess_solver.sv
// guess_solver: iterative guesser that flips mismatched bits using per-bit feedback until solved,
// out of guesses, or timed out waiting for the game.
module guess_solver #(
    parameter logic [5:0] FIRST_GUESS = 6'b000000,
    parameter int         MAX_GUESS   = 3,
    parameter int         TIMEOUT     = 15
) (
    input  logic           clk,
    input  logic           rst,
    guess_solver_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_SOLVED, S_FAIL} state_t;
    state_t     state;
    logic [5:0] guess_q;
    logic [5:0] fb_q;
    logic [7:0] timer;
    logic [7:0] wins_q;
    logic [2:0] attempts_q;
    logic       strobe_q;
    logic       busy_q;
    logic       solved_q;
    logic       fail_q;
    assign bus.guess        = guess_q;
    assign bus.guess_strobe = strobe_q;
    assign bus.busy         = busy_q;
    assign bus.solved       = solved_q;
    assign bus.fail         = fail_q;
    assign bus.attempts     = attempts_q;
    assign bus.wins         = wins_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            guess_q    <= 6'b000000;
            fb_q       <= 6'b000000;
            timer      <= 8'd0;
            wins_q     <= 8'd0;
            attempts_q <= 3'd0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            solved_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else if (bus.abort) begin
            state      <= S_IDLE;
            timer      <= 8'd0;
            attempts_q <= 3'd0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            solved_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state)
                S_IDLE, S_SOLVED, S_FAIL: begin
                    if (bus.start) begin
                        state      <= S_ISSUE;
                        guess_q    <= FIRST_GUESS;
                        attempts_q <= 3'd0;
                        strobe_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        solved_q   <= 1'b0;
                        fail_q     <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    state      <= S_WAIT;
                    attempts_q <= attempts_q + 3'd1;
                    timer      <= 8'd0;
                end
                S_WAIT: begin
                    if (bus.fb_valid) begin
                        state <= S_EVAL;
                        fb_q  <= bus.feedback;
                    end else begin
                        timer <= timer + 8'd1;
                        if (timer == 8'(TIMEOUT - 1)) begin
                            state  <= S_FAIL;
                            busy_q <= 1'b0;
                            fail_q <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    if (&fb_q) begin
                        state    <= S_SOLVED;
                        busy_q   <= 1'b0;
                        solved_q <= 1'b1;
                        wins_q   <= wins_q + 8'(wins_q != 8'hFF);
                    end else if (attempts_q == 3'(MAX_GUESS)) begin
                        state  <= S_FAIL;
                        busy_q <= 1'b0;
                        fail_q <= 1'b1;
                    end else begin
                        // keep matched bits, flip the rest; all-zero feedback simply inverts the guess
                        state    <= S_ISSUE;
                        guess_q  <= guess_q ^ ~fb_q;
                        strobe_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
